// File: rtl/bn128_pkg.sv
// BN128 field constants and the state encoding shared by the exponentiation sequencer.
package bn128_pkg;

  localparam logic [255:0] MONT_ONE =
    256'h0e0a77c19a07df2f666ea36f7879462c0a78eb28f5c70b3dd35d438dc58f0d9d;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SQR_REQ  = 3'd1,
    SQR_WAIT = 3'd2,
    MUL_REQ  = 3'd3,
    MUL_WAIT = 3'd4,
    DONE     = 3'd5
  } mont_exp_state_t;

endpackage

// File: rtl/mont_exp_ctrl_msb_index.sv
// Combinational priority encoder: index of the highest set bit, plus a nonzero flag.
module msb_index #(
  parameter int W     = 256,
  parameter int IDX_W = $clog2(W)
) (
  input  logic [W-1:0]     i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Ascending scan, so the last hit is the most significant set bit.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i_vec[i]) begin
        o_idx   = IDX_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery multiplier.
// Define MONT_EXP_SKIP_LZ_EN to skip leading zero exponent bits (not constant-time).
module mont_exp_ctrl
  import bn128_pkg::*;
#(
  parameter int                  DAT_BITS = 256,
  parameter int                  EXP_BITS = 256,
  parameter int                  CTL_BITS = 8,
  parameter logic [DAT_BITS-1:0] ONE_MONT = MONT_ONE
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_exp_val,
  output logic                         i_exp_rdy,
  input  logic [EXP_BITS+DAT_BITS-1:0] i_exp_dat,
  input  logic [CTL_BITS-1:0]          i_exp_ctl,
  output logic                         o_exp_val,
  input  logic                         o_exp_rdy,
  output logic [DAT_BITS-1:0]          o_exp_dat,
  output logic [CTL_BITS-1:0]          o_exp_ctl,
  output logic                         o_exp_sop,
  output logic                         o_exp_eop,
  output logic                         o_exp_err,
  output logic                         o_mul_val,
  input  logic                         o_mul_rdy,
  output logic [2*DAT_BITS-1:0]        o_mul_dat,
  output logic [CTL_BITS-1:0]          o_mul_ctl,
  output logic                         o_mul_sop,
  output logic                         o_mul_eop,
  output logic                         o_mul_err,
  input  logic                         i_mul_val,
  output logic                         i_mul_rdy,
  input  logic [DAT_BITS-1:0]          i_mul_dat
);

  localparam int IDX_W = $clog2(EXP_BITS);

  mont_exp_state_t     state_q, state_d;
  logic [DAT_BITS-1:0] r_q, r_d, a_q, a_d;
  logic [EXP_BITS-1:0] e_q, e_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CTL_BITS-1:0] ctl_q, ctl_d;
  logic                exp_rdy_q, exp_val_q, mul_val_q, mul_rdy_q;
  logic [DAT_BITS-1:0] in_a_s;
  logic [EXP_BITS-1:0] in_e_s;

  assign in_a_s = i_exp_dat[DAT_BITS-1:0];
  assign in_e_s = i_exp_dat[EXP_BITS+DAT_BITS-1:DAT_BITS];

`ifdef MONT_EXP_SKIP_LZ_EN
  logic [IDX_W-1:0] msb_idx_s;
  logic             msb_vld_s;

  msb_index #(.W(EXP_BITS), .IDX_W(IDX_W)) u_msb_index (
    .i_vec   (in_e_s),
    .o_idx   (msb_idx_s),
    .o_valid (msb_vld_s)
  );
`endif

  // Next-state, accumulator and bit-index update.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    a_d     = a_q;
    e_d     = e_q;
    idx_d   = idx_q;
    ctl_d   = ctl_q;
    case (state_q)
      IDLE: begin
        if (i_exp_val && exp_rdy_q) begin
          a_d   = in_a_s;
          e_d   = in_e_s;
          ctl_d = i_exp_ctl;
`ifdef MONT_EXP_SKIP_LZ_EN
          // The top set bit is consumed by starting from r = a.
          r_d   = in_a_s;
          idx_d = msb_idx_s;
          if (!msb_vld_s) begin
            r_d     = ONE_MONT;
            state_d = DONE;
          end else if (msb_idx_s == '0) begin
            state_d = DONE;
          end else begin
            idx_d   = msb_idx_s - IDX_W'(1);
            state_d = SQR_REQ;
          end
`else
          r_d     = ONE_MONT;
          idx_d   = IDX_W'(EXP_BITS - 1);
          state_d = SQR_REQ;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SQR_REQ, MUL_REQ: begin
        if (o_mul_rdy && mul_val_q) begin
          state_d = (state_q == SQR_REQ) ? SQR_WAIT : MUL_WAIT;
        end else begin
          state_d = state_q;
        end
      end
      SQR_WAIT, MUL_WAIT: begin
        if (i_mul_val && mul_rdy_q) begin
          r_d = i_mul_dat;
          if ((state_q == SQR_WAIT) && e_q[idx_q]) begin
            state_d = MUL_REQ;
          end else if (idx_q == '0) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = SQR_REQ;
          end
        end else begin
          state_d = state_q;
        end
      end
      DONE: begin
        if (o_exp_rdy && exp_val_q) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registers; handshake flags are decoded from the next state so they are flop outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      r_q       <= '0;
      a_q       <= '0;
      e_q       <= '0;
      idx_q     <= '0;
      ctl_q     <= '0;
      exp_rdy_q <= 1'b0;
      exp_val_q <= 1'b0;
      mul_val_q <= 1'b0;
      mul_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      a_q       <= a_d;
      e_q       <= e_d;
      idx_q     <= idx_d;
      ctl_q     <= ctl_d;
      exp_rdy_q <= (state_d == IDLE);
      exp_val_q <= (state_d == DONE);
      mul_val_q <= (state_d == SQR_REQ) || (state_d == MUL_REQ);
      mul_rdy_q <= (state_d == SQR_WAIT) || (state_d == MUL_WAIT);
    end
  end

  assign i_exp_rdy = exp_rdy_q;
  assign o_exp_val = exp_val_q;
  assign o_exp_dat = r_q;
  assign o_exp_ctl = ctl_q;
  assign o_exp_sop = 1'b1;
  assign o_exp_eop = 1'b1;
  assign o_exp_err = 1'b0;
  assign o_mul_val = mul_val_q;
  assign o_mul_dat = {(state_q == MUL_REQ) ? a_q : r_q, r_q};
  assign o_mul_ctl = ctl_q;
  assign o_mul_sop = 1'b1;
  assign o_mul_eop = 1'b1;
  assign o_mul_err = 1'b0;
  assign i_mul_rdy = mul_rdy_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Self-checking bench for mont_exp_ctrl with a behavioural Montgomery multiplier responder.
`timescale 1ns/1ps
module tb_mont_exp_ctrl;
  import bn128_pkg::*;

  localparam int DB = 256;
  localparam int EB = 256;
  localparam int CB = 8;
  localparam logic [DB-1:0] P =
    256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

  typedef struct packed {
    logic [DB-1:0] dat;
    logic [CB-1:0] ctl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              i_exp_val = 1'b0;
  logic              i_exp_rdy;
  logic [EB+DB-1:0]  i_exp_dat = '0;
  logic [CB-1:0]     i_exp_ctl = '0;
  logic              o_exp_val;
  logic              o_exp_rdy = 1'b0;
  logic [DB-1:0]     o_exp_dat;
  logic [CB-1:0]     o_exp_ctl;
  logic              o_exp_sop, o_exp_eop, o_exp_err;
  logic              o_mul_val;
  logic              o_mul_rdy = 1'b0;
  logic [2*DB-1:0]   o_mul_dat;
  logic [CB-1:0]     o_mul_ctl;
  logic              o_mul_sop, o_mul_eop, o_mul_err;
  logic              i_mul_val = 1'b0;
  logic              i_mul_rdy;
  logic [DB-1:0]     i_mul_dat = '0;

  mont_exp_ctrl #(.DAT_BITS(DB), .EXP_BITS(EB), .CTL_BITS(CB)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_exp_val(i_exp_val), .i_exp_rdy(i_exp_rdy), .i_exp_dat(i_exp_dat), .i_exp_ctl(i_exp_ctl),
    .o_exp_val(o_exp_val), .o_exp_rdy(o_exp_rdy), .o_exp_dat(o_exp_dat), .o_exp_ctl(o_exp_ctl),
    .o_exp_sop(o_exp_sop), .o_exp_eop(o_exp_eop), .o_exp_err(o_exp_err),
    .o_mul_val(o_mul_val), .o_mul_rdy(o_mul_rdy), .o_mul_dat(o_mul_dat), .o_mul_ctl(o_mul_ctl),
    .o_mul_sop(o_mul_sop), .o_mul_eop(o_mul_eop), .o_mul_err(o_mul_err),
    .i_mul_val(i_mul_val), .i_mul_rdy(i_mul_rdy), .i_mul_dat(i_mul_dat)
  );

  int            n_checks = 0;
  int            n_errors = 0;
  int            mul_cnt = 0;
  int            jobs_done = 0;
  bit            mul_stall = 1'b0;
  bit            exp_stall = 1'b0;
  logic [DB-1:0] one_mont;
  logic [CB-1:0] cur_ctl = '0;
  logic [DB-1:0] last_dat = '0;
  exp_t          sb_q[$];

  // ---------------- field model ----------------
  function automatic logic [DB-1:0] fe_mul_mont(input logic [DB-1:0] x, input logic [DB-1:0] y);
    logic [DB+1:0] t;
    t = '0;
    for (int i = 0; i < DB; i++) begin
      if (y[i]) t = t + {2'b00, x};
      if (t[0]) t = t + {2'b00, P};
      t = t >> 1;
    end
    if (t >= {2'b00, P}) t = t - {2'b00, P};
    return t[DB-1:0];
  endfunction

  function automatic logic [DB-1:0] to_mont(input logic [DB-1:0] x);
    logic [DB:0] t;
    t = {1'b0, x};
    for (int i = 0; i < DB; i++) begin
      t = t << 1;
      if (t >= {1'b0, P}) t = t - {1'b0, P};
    end
    return t[DB-1:0];
  endfunction

  function automatic logic [DB-1:0] mont_pow(input logic [DB-1:0] a, input logic [EB-1:0] e);
    logic [DB-1:0] r;
    r = one_mont;
    for (int i = EB - 1; i >= 0; i--) begin
      r = fe_mul_mont(r, r);
      if (e[i]) r = fe_mul_mont(r, a);
    end
    return r;
  endfunction

  function automatic int exp_count(input logic [EB-1:0] e);
    int pc;
    pc = 0;
    for (int i = 0; i < EB; i++) if (e[i]) pc++;
`ifdef MONT_EXP_SKIP_LZ_EN
    begin
      int msb;
      msb = 0;
      for (int i = 0; i < EB; i++) if (e[i]) msb = i;
      return (pc == 0) ? 0 : msb + pc - 1;
    end
`else
    return EB + pc;
`endif
  endfunction

  function automatic logic [DB-1:0] rand_bits();
    logic [DB-1:0] x;
    for (int i = 0; i < DB / 32; i++) x[i*32 +: 32] = $urandom;
    return x;
  endfunction

  function automatic logic [DB-1:0] rand_fe();
    logic [DB-1:0] x;
    x = rand_bits();
    while (x >= P) x = x - P;
    if (x == '0) x = 256'd1;
    return x;
  endfunction

  // ---------------- multiplier responder (1-cycle latency) ----------------
  logic            req_hs = 1'b0, rsp_hs = 1'b0, prev_stall = 1'b0;
  logic [2*DB-1:0] req_dat = '0, prev_dat = '0;
  logic [CB-1:0]   req_ctl = '0;

  always @(negedge clk) begin
    if (rst) begin
      i_mul_val  = 1'b0;
      o_mul_rdy  = 1'b0;
      req_hs     = 1'b0;
      rsp_hs     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (o_mul_val !== 1'b1 || o_mul_dat !== prev_dat) begin
          n_errors++;
          $display("FAIL mul_req_stable: val=%0b dat=%h, required val=1 dat=%h", o_mul_val, o_mul_dat, prev_dat);
        end
      end
      if (rsp_hs) i_mul_val = 1'b0;
      if (req_hs) begin
        mul_cnt++;
        n_checks++;
        if (req_ctl !== cur_ctl) begin
          n_errors++;
          $display("FAIL mul_ctl: got %h, required %h", req_ctl, cur_ctl);
        end
        i_mul_dat = fe_mul_mont(req_dat[DB-1:0], req_dat[2*DB-1:DB]);
        i_mul_val = 1'b1;
      end
      o_mul_rdy  = mul_stall ? 1'($urandom_range(0, 1)) : 1'b1;
      req_hs     = o_mul_val && o_mul_rdy;
      req_dat    = o_mul_dat;
      req_ctl    = o_mul_ctl;
      rsp_hs     = i_mul_val && i_mul_rdy;
      prev_stall = o_mul_val && !o_mul_rdy;
      prev_dat   = o_mul_dat;
    end
  end

  // ---------------- result monitor / scoreboard ----------------
  logic          exp_hs = 1'b0;
  logic [DB-1:0] exp_dat_c = '0;
  logic [CB-1:0] exp_ctl_c = '0;
  exp_t          mon_exp;

  always @(negedge clk) begin
    if (rst) begin
      o_exp_rdy = 1'b0;
      exp_hs    = 1'b0;
    end else begin
      if (exp_hs) begin
        jobs_done++;
        last_dat = exp_dat_c;
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL exp_unexpected: result %h with no job outstanding", exp_dat_c);
        end else begin
          mon_exp = sb_q.pop_front();
          if (exp_dat_c !== mon_exp.dat || exp_ctl_c !== mon_exp.ctl) begin
            n_errors++;
            $display("FAIL exp_result: got dat=%h ctl=%h, required dat=%h ctl=%h",
                     exp_dat_c, exp_ctl_c, mon_exp.dat, mon_exp.ctl);
          end
        end
      end
      o_exp_rdy = exp_stall ? 1'($urandom_range(0, 1)) : 1'b1;
      exp_hs    = o_exp_val && o_exp_rdy;
      exp_dat_c = o_exp_dat;
      exp_ctl_c = o_exp_ctl;
    end
  end

  // ---------------- drivers ----------------
  task automatic send_job(input logic [DB-1:0] a, input logic [EB-1:0] e,
                          input logic [CB-1:0] ctl, input logic [DB-1:0] expd);
    int   n;
    exp_t x;
    n = 0;
    @(negedge clk);
    i_exp_val = 1'b1;
    i_exp_dat = {e, a};
    i_exp_ctl = ctl;
    while (i_exp_rdy !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (i_exp_rdy !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: i_exp_rdy=%0b, required 1", i_exp_rdy);
    end else begin
      x.dat = expd;
      x.ctl = ctl;
      sb_q.push_back(x);
      cur_ctl = ctl;
      mul_cnt = 0;
    end
    @(negedge clk);
    i_exp_val = 1'b0;
  endtask

  task automatic wait_jobs(input int target);
    int n;
    n = 0;
    while (jobs_done < target && n < 50000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (jobs_done < target) begin
      n_errors++;
      $display("FAIL job_timeout: done %0d, required %0d", jobs_done, target);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({i_exp_rdy, o_exp_val, o_mul_val, i_mul_rdy} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_handshake: rdy/val=%b, required 0000", {i_exp_rdy, o_exp_val, o_mul_val, i_mul_rdy});
    end
    n_checks++;
    if (dut.state_q !== IDLE) begin
      n_errors++;
      $display("FAIL reset_state: got %0d, required IDLE", dut.state_q);
    end
    n_checks++;
    if (o_exp_dat !== '0 || o_mul_ctl !== '0) begin
      n_errors++;
      $display("FAIL reset_regs: r=%h ctl=%h, required 0", o_exp_dat, o_mul_ctl);
    end
    n_checks++;
    if ({o_exp_sop, o_exp_eop, o_exp_err, o_mul_sop, o_mul_eop, o_mul_err} !== 6'b110110) begin
      n_errors++;
      $display("FAIL framing: got %b, required 110110",
               {o_exp_sop, o_exp_eop, o_exp_err, o_mul_sop, o_mul_eop, o_mul_err});
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (i_exp_rdy !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release_rdy: got %0b, required 1", i_exp_rdy);
    end
  endtask

  task automatic test_exp_zero();
    logic [DB-1:0] a;
    logic          lat_ok;
    int            base;
    a    = rand_fe();
    base = jobs_done;
    send_job(a, '0, 8'h11, one_mont);
`ifdef MONT_EXP_SKIP_LZ_EN
    lat_ok = (o_exp_val === 1'b1);
`else
    lat_ok = (o_mul_val === 1'b1);
`endif
    n_checks++;
    if (!lat_ok) begin
      n_errors++;
      $display("FAIL accept_latency: o_mul_val=%0b o_exp_val=%0b one cycle after accept", o_mul_val, o_exp_val);
    end
    wait_jobs(base + 1);
    n_checks++;
    if (mul_cnt != exp_count('0)) begin
      n_errors++;
      $display("FAIL e0_mul_count: got %0d, required %0d", mul_cnt, exp_count('0));
    end
  endtask

  task automatic test_exp_one();
    logic [DB-1:0] a;
    logic [EB-1:0] e;
    int            base;
    a    = rand_fe();
    e    = 256'd1;
    base = jobs_done;
    send_job(a, e, 8'h22, a);
    wait_jobs(base + 1);
    n_checks++;
    if (mul_cnt != exp_count(e)) begin
      n_errors++;
      $display("FAIL e1_mul_count: got %0d, required %0d", mul_cnt, exp_count(e));
    end
  endtask

  task automatic test_exp_two();
    int base;
    base = jobs_done;
    send_job(to_mont(256'd3), 256'd2, 8'h33, to_mont(256'd9));
    wait_jobs(base + 1);
  endtask

  task automatic test_inverse();
    logic [DB-1:0] a;
    logic [DB-1:0] prod;
    int            base;
    a    = rand_fe();
    base = jobs_done;
    send_job(a, P - 256'd2, 8'h44, mont_pow(a, P - 256'd2));
    wait_jobs(base + 1);
    prod = fe_mul_mont(last_dat, a);
    n_checks++;
    if (prod !== one_mont) begin
      n_errors++;
      $display("FAIL inverse: a*r=%h, required %h", prod, one_mont);
    end
  endtask

  task automatic test_back_to_back();
    logic [DB-1:0] a;
    logic [EB-1:0] e;
    int            base;
    mul_stall = 1'b1;
    exp_stall = 1'b1;
    base      = jobs_done;
    for (int j = 0; j < 20; j++) begin
      a = rand_fe();
      e = rand_bits();
      send_job(a, e, 8'(8'h80 + j), mont_pow(a, e));
    end
    wait_jobs(base + 20);
    mul_stall = 1'b0;
    exp_stall = 1'b0;
  endtask

  task automatic test_reset_mid_job();
    int n;
    int base;
    n = 0;
    send_job(rand_fe(), '1, 8'h66, '0);
    while (!(mul_cnt >= 20 && dut.state_q == MUL_WAIT) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (dut.state_q !== MUL_WAIT) begin
      n_errors++;
      $display("FAIL mid_job_reach: state %0d, required MUL_WAIT", dut.state_q);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({o_mul_val, o_exp_val, i_mul_rdy, i_exp_rdy} !== 4'b0000) begin
      n_errors++;
      $display("FAIL mid_job_reset: vals/rdys=%b, required 0000", {o_mul_val, o_exp_val, i_mul_rdy, i_exp_rdy});
    end
    sb_q.delete();
    rst  = 1'b0;
    base = jobs_done;
    send_job(to_mont(256'd2), 256'd3, 8'h5A, to_mont(256'd8));
    wait_jobs(base + 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    one_mont = to_mont(256'd1);
    test_reset();
    test_exp_zero();
    test_exp_one();
    test_exp_two();
    test_inverse();
    test_back_to_back();
    test_reset_mid_job();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
